bank_sram_sequencer: RTL and testbench

Parametrised next-generation bank data-SRAM controller; sits between the bank ISU and the data SRAM, xbar return path, write buffer (wbuf) and BIU.
Executes one ISU request at a time (WRITE, READ, READ_WITH_LINEFILL, WRITE_BACK) through an explicit FSM over a cacheline of OFFSETS sub-blocks.

---
 rtl/bank_sram_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_bank_sram_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_sram_sequencer.sv
// bank_sram_sequencer: bank data-SRAM controller between ISU, data SRAM, xbar, wbuf and BIU.
// Latency: READ data valid 3 cycles after accept; done pulses the cycle after the last write/handshake.
// Backpressure: one request in flight (ready only in IDLE); outbound valids hold with stable payload until ready.
//
// Optional feature macro: BANK_SC_WB_SKIP_CLEAN_EN (WRITE_BACK skips offsets that are not dirty).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   isu_sc_*                     request handshake and fields (latched on accept)
//   sc_isu_done_o                one-cycle completion pulse
//   sc_xbar_*                    read/linefill return data (valid/ready)
//   sc_biu_*                     writeback beats with {set_way, offset} and last flag (valid/ready)
//   sc_wbuf_req_* / sc_wbuf_rtn_* write-buffer read request and data return
//   sc_busy_o                    sequencer not idle

// Single-port SRAM: one access per cycle, read data registered (valid the cycle after a read).
module ram_sp #(
  parameter int AW = 7,
  parameter int DW = 128
) (
  input  logic          clk_i,
  input  logic          me,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (me) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

module bank_sram_sequencer #(
  parameter int DW      = 128,
  parameter int OFFSETS = 2,
  parameter int SWW     = 6,
  parameter int CHW     = 2,
  parameter int ROBW    = 3,
  parameter int WBW     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       isu_sc_valid_i,
  output logic                       isu_sc_ready_o,
  input  logic [2:0]                 isu_sc_opcode_i,
  input  logic [SWW-1:0]             isu_sc_set_way_i,
  input  logic [$clog2(OFFSETS)-1:0] isu_sc_offset_i,
  input  logic [CHW-1:0]             isu_sc_channel_id_i,
  input  logic [ROBW-1:0]            isu_sc_xbar_rob_num_i,
  input  logic [WBW-1:0]             isu_sc_wbuffer_id_i,
  input  logic [2*OFFSETS-1:0]       isu_sc_line_state_i,
  input  logic [OFFSETS*DW-1:0]      isu_sc_linefill_data_i,
  output logic                       sc_isu_done_o,
  output logic                       sc_xbar_valid_o,
  input  logic                       sc_xbar_ready_i,
  output logic [CHW-1:0]             sc_xbar_channel_id_o,
  output logic [ROBW-1:0]            sc_xbar_rob_num_o,
  output logic [DW-1:0]              sc_xbar_data_o,
  output logic                       sc_biu_valid_o,
  input  logic                       sc_biu_ready_i,
  output logic [DW-1:0]              sc_biu_data_o,
  output logic [SWW+$clog2(OFFSETS)-1:0] sc_biu_set_way_offset_o,
  output logic                       sc_biu_last_o,
  output logic                       sc_wbuf_req_valid_o,
  input  logic                       sc_wbuf_req_ready_i,
  output logic [WBW-1:0]             sc_wbuf_req_wbuffer_id_o,
  input  logic                       sc_wbuf_rtn_valid_i,
  input  logic [DW-1:0]              sc_wbuf_rtn_data_i,
  output logic                       sc_busy_o
);

  localparam int OFFW = $clog2(OFFSETS);
  localparam int AW   = SWW + OFFW;

  localparam logic [2:0] OP_WRITE      = 3'd0;
  localparam logic [2:0] OP_READ       = 3'd1;
  localparam logic [2:0] OP_LINEFILL   = 3'd2;
  localparam logic [2:0] OP_WRITE_BACK = 3'd3;

  typedef enum logic [3:0] {
    IDLE, WB_REQ, WB_WAIT, RD_ISSUE, RD_CAP, XB_SEND, LF, WB_RD, WB_CAP, BIU_SEND, DONE
  } state_t;

  typedef struct packed {
    logic [SWW-1:0]  set_way;
    logic [CHW-1:0]  channel_id;
    logic [ROBW-1:0] rob_num;
    logic [WBW-1:0]  wbuffer_id;
  } req_t;

  state_t state_q, state_d;
  logic [OFFW-1:0]    cur_q, cur_d;      // offset currently being accessed
  logic [OFFSETS-1:0] pend_q, pend_d;    // offsets still to be written (LF) or sent (WB)
  logic               xb_done_q, xb_done_d;

  req_t                        req_q, req_d;
  logic [OFFSETS-1:0][DW-1:0]  lf_data_q;
  logic [OFFSETS-1:0][DW-1:0]  lf_in;
  logic [OFFSETS-1:0][1:0]     ls_in;
  logic [DW-1:0]               hold_q, hold_d;
  logic                        req_ld, hold_ld;

  logic [OFFSETS-1:0] empty_mask, wb_mask, cur_oh, rem_mask;
  logic               xb_hs_done;

  logic          ram_me, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  assign lf_in = isu_sc_linefill_data_i;
  assign ls_in = isu_sc_line_state_i;

  assign req_d.set_way    = isu_sc_set_way_i;
  assign req_d.channel_id = isu_sc_channel_id_i;
  assign req_d.rob_num    = isu_sc_xbar_rob_num_i;
  assign req_d.wbuffer_id = isu_sc_wbuffer_id_i;

  always_comb begin
    empty_mask = '0;
    wb_mask    = '0;
    for (int i = 0; i < OFFSETS; i++) begin
      empty_mask[i] = (ls_in[i] == 2'b00);
`ifdef BANK_SC_WB_SKIP_CLEAN_EN
      // 10 and 11 both count as dirty
      wb_mask[i] = ls_in[i][1];
`else
      wb_mask[i] = 1'b1;
`endif
    end
  end

  // Pending set with the current offset retired; empty means the current access is the last one.
  assign cur_oh   = OFFSETS'(1) << cur_q;
  assign rem_mask = pend_q & ~cur_oh;

  // First member of mask found scanning upward from start, wrapping modulo OFFSETS.
  function automatic logic [OFFW-1:0] first_from(input logic [OFFSETS-1:0] mask,
                                                 input logic [OFFW-1:0]    start);
    logic [OFFW-1:0] idx;
    logic            found;
    first_from = start;
    found      = 1'b0;
    for (int k = 0; k < OFFSETS; k++) begin
      idx = start + OFFW'(k);
      if (!found && mask[idx]) begin
        first_from = idx;
        found      = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      pend_q    <= '0;
      xb_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      xb_done_q <= xb_done_d;
    end
  end

  // Payload registers carry no reset; they are only observed behind a valid.
  always_ff @(posedge clk_i) begin
    if (req_ld) begin
      req_q     <= req_d;
      lf_data_q <= lf_in;
    end
    if (hold_ld) begin
      hold_q <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    xb_done_d = xb_done_q;
    req_ld    = 1'b0;
    hold_ld   = 1'b0;
    hold_d    = ram_rdata;
    ram_me    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = sc_wbuf_rtn_data_i;
    xb_hs_done = 1'b0;
    isu_sc_ready_o      = 1'b0;
    sc_isu_done_o       = 1'b0;
    sc_xbar_valid_o     = 1'b0;
    sc_biu_valid_o      = 1'b0;
    sc_biu_last_o       = 1'b0;
    sc_wbuf_req_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        isu_sc_ready_o = 1'b1;
        if (isu_sc_valid_i) begin
          req_ld    = 1'b1;
          cur_d     = isu_sc_offset_i;
          xb_done_d = 1'b0;
          case (isu_sc_opcode_i)
            OP_WRITE: state_d = WB_REQ;
            OP_READ:  state_d = RD_ISSUE;
            OP_LINEFILL: begin
              // Return data comes straight from the request, so xbar can go while SRAM fills.
              state_d = LF;
              pend_d  = empty_mask | (OFFSETS'(1) << isu_sc_offset_i);
              hold_ld = 1'b1;
              hold_d  = lf_in[isu_sc_offset_i];
            end
            OP_WRITE_BACK: begin
              pend_d  = wb_mask;
              cur_d   = first_from(wb_mask, OFFW'(0));
              state_d = (wb_mask == '0) ? DONE : WB_RD;
            end
            default: state_d = DONE;
          endcase
        end
      end

      WB_REQ: begin
        sc_wbuf_req_valid_o = 1'b1;
        if (sc_wbuf_req_ready_i) state_d = WB_WAIT;
      end

      WB_WAIT: begin
        if (sc_wbuf_rtn_valid_i) begin
          ram_me  = 1'b1;
          ram_we  = 1'b1;
          state_d = DONE;
        end
      end

      RD_ISSUE: begin
        ram_me  = 1'b1;
        state_d = RD_CAP;
      end

      RD_CAP: begin
        hold_ld = 1'b1;
        state_d = XB_SEND;
      end

      XB_SEND: begin
        sc_xbar_valid_o = 1'b1;
        if (sc_xbar_ready_i) state_d = DONE;
      end

      LF: begin
        sc_xbar_valid_o = !xb_done_q;
        if (pend_q != '0) begin
          ram_me    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = lf_data_q[cur_q];
          pend_d    = rem_mask;
          cur_d     = first_from(rem_mask, cur_q + OFFW'(1));
        end
        // Writes and the xbar handshake finish independently; leave once both are through.
        xb_hs_done = xb_done_q | sc_xbar_ready_i;
        xb_done_d  = xb_hs_done;
        if ((rem_mask == '0) && xb_hs_done) state_d = DONE;
      end

      WB_RD: begin
        ram_me  = 1'b1;
        state_d = WB_CAP;
      end

      WB_CAP: begin
        hold_ld = 1'b1;
        state_d = BIU_SEND;
      end

      BIU_SEND: begin
        sc_biu_valid_o = 1'b1;
        sc_biu_last_o  = (rem_mask == '0);
        if (sc_biu_ready_i) begin
          pend_d = rem_mask;
          if (rem_mask == '0) begin
            state_d = DONE;
          end else begin
            cur_d   = first_from(rem_mask, OFFW'(0));
            state_d = WB_RD;
          end
        end
      end

      DONE: begin
        sc_isu_done_o = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign ram_addr = {req_q.set_way, cur_q};

  assign sc_xbar_channel_id_o     = req_q.channel_id;
  assign sc_xbar_rob_num_o        = req_q.rob_num;
  assign sc_xbar_data_o           = hold_q;
  assign sc_biu_data_o            = hold_q;
  assign sc_biu_set_way_offset_o  = {req_q.set_way, cur_q};
  assign sc_wbuf_req_wbuffer_id_o = req_q.wbuffer_id;
  assign sc_busy_o                = (state_q != IDLE);

  ram_sp #(.AW(AW), .DW(DW)) u_ram (
    .clk_i (clk_i),
    .me    (ram_me),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_bank_sram_sequencer.sv
// tb_bank_sram_sequencer: randomized requests against a line-level memory model of bank_sram_sequencer.
// Latency: each request is driven, then tracked until its done pulse.
// Backpressure: xbar/BIU/wbuf readies are stalled and randomized per request.
module tb_bank_sram_sequencer;

  localparam int DW      = 64;
  localparam int OFFSETS = 4;
  localparam int OFFW    = 2;
  localparam int SWW     = 4;
  localparam int CHW     = 2;
  localparam int ROBW    = 3;
  localparam int WBW     = 8;
  localparam int AW      = SWW + OFFW;

  logic                  clk, rst;
  logic                  isu_valid, isu_ready;
  logic [2:0]            opcode;
  logic [SWW-1:0]        set_way;
  logic [OFFW-1:0]       offset;
  logic [CHW-1:0]        chan;
  logic [ROBW-1:0]       rob_num;
  logic [WBW-1:0]        wbuf_id;
  logic [2*OFFSETS-1:0]  line_state;
  logic [OFFSETS*DW-1:0] lf_data;
  logic                  done, busy;
  logic                  xb_valid, xb_ready;
  logic [CHW-1:0]        xb_chan;
  logic [ROBW-1:0]       xb_rob;
  logic [DW-1:0]         xb_data;
  logic                  biu_valid, biu_ready, biu_last;
  logic [DW-1:0]         biu_data;
  logic [AW-1:0]         biu_addr;
  logic                  wq_valid, wq_ready;
  logic [WBW-1:0]        wq_id;
  logic                  rtn_valid;
  logic [DW-1:0]         rtn_data;

  bank_sram_sequencer #(
    .DW(DW), .OFFSETS(OFFSETS), .SWW(SWW), .CHW(CHW), .ROBW(ROBW), .WBW(WBW)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .isu_sc_valid_i           (isu_valid),
    .isu_sc_ready_o           (isu_ready),
    .isu_sc_opcode_i          (opcode),
    .isu_sc_set_way_i         (set_way),
    .isu_sc_offset_i          (offset),
    .isu_sc_channel_id_i      (chan),
    .isu_sc_xbar_rob_num_i    (rob_num),
    .isu_sc_wbuffer_id_i      (wbuf_id),
    .isu_sc_line_state_i      (line_state),
    .isu_sc_linefill_data_i   (lf_data),
    .sc_isu_done_o            (done),
    .sc_xbar_valid_o          (xb_valid),
    .sc_xbar_ready_i          (xb_ready),
    .sc_xbar_channel_id_o     (xb_chan),
    .sc_xbar_rob_num_o        (xb_rob),
    .sc_xbar_data_o           (xb_data),
    .sc_biu_valid_o           (biu_valid),
    .sc_biu_ready_i           (biu_ready),
    .sc_biu_data_o            (biu_data),
    .sc_biu_set_way_offset_o  (biu_addr),
    .sc_biu_last_o            (biu_last),
    .sc_wbuf_req_valid_o      (wq_valid),
    .sc_wbuf_req_ready_i      (wq_ready),
    .sc_wbuf_req_wbuffer_id_o (wq_id),
    .sc_wbuf_rtn_valid_i      (rtn_valid),
    .sc_wbuf_rtn_data_i       (rtn_data),
    .sc_busy_o                (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: contents per {set_way, offset}, plus whether the bench has ever written it.
  logic [DW-1:0] mem_m [2**AW];
  bit            known [2**AW];

  function automatic logic [OFFSETS*DW-1:0] rand_line();
    logic [OFFSETS*DW-1:0] v;
    for (int k = 0; k < OFFSETS*DW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the done pulse.
  task automatic run_op(input logic [2:0] op, input logic [SWW-1:0] s, input logic [OFFW-1:0] o,
                        input logic [2*OFFSETS-1:0] l, input logic [OFFSETS*DW-1:0] d,
                        input logic [DW-1:0] wd, input int stall, input bit rr);
    logic [CHW-1:0]  ch;
    logic [ROBW-1:0] rb;
    logic [WBW-1:0]  wb;
    logic [OFFSETS-1:0][DW-1:0] dd;
    logic [OFFSETS-1:0][1:0]    ll;
    int wa_q[$];
    logic [DW-1:0] wd_q[$];
    int ra_q[$];
    logic [DW-1:0] xb_q[$];
    bit xbk_q[$];
    int ba_q[$];
    logic [DW-1:0] bd_q[$];
    bit bk_q[$];
    int first_xb, n_wbuf_exp, idx, c, last_ev;
    int wr_n, rd_n, xb_n, bi_n, wq_n, xs, bs, ws, rtn_cnt;
    bit done_seen, xb_pend, bi_pend, wq_pend, xb_first, member;

    dd = d;
    ll = l;
    ch = CHW'($urandom);
    rb = ROBW'($urandom);
    wb = WBW'($urandom);
    first_xb   = -1;
    n_wbuf_exp = 0;

    case (op)
      3'd0: begin
        wa_q.push_back(s*OFFSETS + o);
        wd_q.push_back(wd);
        n_wbuf_exp = 1;
      end
      3'd1: begin
        ra_q.push_back(s*OFFSETS + o);
        xb_q.push_back(mem_m[s*OFFSETS + o]);
        xbk_q.push_back(known[s*OFFSETS + o]);
        first_xb = 3;
      end
      3'd2: begin
        for (int k = 0; k < OFFSETS; k++) begin
          idx = (o + k) % OFFSETS;
          if (k == 0 || ll[idx] == 2'b00) begin
            wa_q.push_back(s*OFFSETS + idx);
            wd_q.push_back(dd[idx]);
          end
        end
        xb_q.push_back(dd[o]);
        xbk_q.push_back(1'b1);
        first_xb = 1;
      end
      3'd3: begin
        for (int i = 0; i < OFFSETS; i++) begin
`ifdef BANK_SC_WB_SKIP_CLEAN_EN
          member = ll[i][1];
`else
          member = 1'b1;
`endif
          if (member) begin
            ra_q.push_back(s*OFFSETS + i);
            ba_q.push_back(s*OFFSETS + i);
            bd_q.push_back(mem_m[s*OFFSETS + i]);
            bk_q.push_back(known[s*OFFSETS + i]);
          end
        end
      end
      default: ;
    endcase

    isu_valid  = 1'b1;
    opcode     = op;
    set_way    = s;
    offset     = o;
    chan       = ch;
    rob_num    = rb;
    wbuf_id    = wb;
    line_state = l;
    lf_data    = d;
    chk("accept_rdy", DW'(isu_ready), DW'(1));

    c = 0; last_ev = 0;
    wr_n = 0; rd_n = 0; xb_n = 0; bi_n = 0; wq_n = 0;
    xs = 0; bs = 0; ws = 0; rtn_cnt = -1;
    done_seen = 0; xb_pend = 0; bi_pend = 0; wq_pend = 0; xb_first = 0;

    while (!done_seen && c < 300) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        isu_valid  = 1'b0;
        opcode     = 3'($urandom);
        set_way    = SWW'($urandom);
        offset     = OFFW'($urandom);
        line_state = 8'($urandom);
        lf_data    = rand_line();
        chk("busy_set", DW'(busy), DW'(1));
        chk("rdy_busy", DW'(isu_ready), DW'(0));
      end

      if (done) begin
        done_seen = 1;
        chk("done_cyc", DW'(c), DW'(last_ev + 1));
      end

      // xbar return
      if (xb_pend) chk("xb_hold", DW'(xb_valid), DW'(1));
      xb_ready = 1'b0;
      if (xb_valid) begin
        if (!xb_first) begin
          xb_first = 1;
          chk("xb_first_cyc", DW'(c), DW'(first_xb));
        end
        if (xb_n < xb_q.size()) begin
          if (xbk_q[xb_n]) chk("xb_data", xb_data, xb_q[xb_n]);
          chk("xb_chan", DW'(xb_chan), DW'(ch));
          chk("xb_rob", DW'(xb_rob), DW'(rb));
        end else begin
          chk("xb_extra", DW'(xb_n), DW'(xb_q.size()));
        end
        xb_ready = (xs >= stall) && (!rr || $urandom_range(0, 1) == 1);
        xs++;
        if (xb_ready) begin
          xb_n++;
          last_ev = c;
          xs = 0;
        end
      end
      xb_pend = xb_valid && !xb_ready;

      // BIU writeback
      if (bi_pend) chk("biu_hold", DW'(biu_valid), DW'(1));
      biu_ready = 1'b0;
      if (biu_valid) begin
        if (bi_n < ba_q.size()) begin
          if (bk_q[bi_n]) chk("biu_data", biu_data, bd_q[bi_n]);
          chk("biu_addr", DW'(biu_addr), DW'(ba_q[bi_n]));
          chk("biu_last", DW'(biu_last), DW'(bi_n == ba_q.size() - 1));
        end else begin
          chk("biu_extra", DW'(bi_n), DW'(ba_q.size()));
        end
        biu_ready = (bs >= stall) && (!rr || $urandom_range(0, 1) == 1);
        bs++;
        if (biu_ready) begin
          bi_n++;
          last_ev = c;
          bs = 0;
        end
      end
      bi_pend = biu_valid && !biu_ready;

      // wbuf data return goes first so a fresh request handshake cannot return in the same cycle
      rtn_valid = 1'b0;
      rtn_data  = {$urandom, $urandom};
      if (rtn_cnt == 0) begin
        rtn_valid = 1'b1;
        rtn_data  = wd;
        rtn_cnt   = -1;
      end else if (rtn_cnt > 0) begin
        rtn_cnt--;
      end

      if (wq_pend) chk("wbuf_hold", DW'(wq_valid), DW'(1));
      wq_ready = 1'b0;
      if (wq_valid) begin
        chk("wbuf_id", DW'(wq_id), DW'(wb));
        wq_ready = (ws >= stall) && (!rr || $urandom_range(0, 1) == 1);
        ws++;
        if (wq_ready) begin
          wq_n++;
          last_ev = c;
          ws = 0;
          rtn_cnt = $urandom_range(0, 3);
        end
      end
      wq_pend = wq_valid && !wq_ready;

      // SRAM port, sampled after this cycle's inputs have settled
      #1;
      if (dut.ram_me) begin
        if (dut.ram_we) begin
          if (wr_n < wa_q.size()) begin
            chk("wr_addr", DW'(dut.ram_addr), DW'(wa_q[wr_n]));
            chk("wr_data", dut.ram_wdata, wd_q[wr_n]);
          end
          wr_n++;
          last_ev = c;
        end else begin
          if (rd_n < ra_q.size()) chk("rd_addr", DW'(dut.ram_addr), DW'(ra_q[rd_n]));
          if (op == 3'd3) chk("rd_after_hs", DW'(rd_n), DW'(bi_n));
          rd_n++;
        end
      end
    end

    if (!done_seen) chk("timeout", DW'(0), DW'(1));
    chk("n_writes", DW'(wr_n), DW'(wa_q.size()));
    chk("n_reads", DW'(rd_n), DW'(ra_q.size()));
    chk("n_xbar", DW'(xb_n), DW'(xb_q.size()));
    chk("n_biu", DW'(bi_n), DW'(ba_q.size()));
    chk("n_wbuf", DW'(wq_n), DW'(n_wbuf_exp));

    foreach (wa_q[i]) begin
      mem_m[wa_q[i]] = wd_q[i];
      known[wa_q[i]] = 1'b1;
    end

    xb_ready  = 1'b0;
    biu_ready = 1'b0;
    wq_ready  = 1'b0;
    rtn_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", DW'(done), DW'(0));
    chk("idle_rdy", DW'(isu_ready), DW'(1));
    chk("idle_busy", DW'(busy), DW'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rdy"}, DW'(isu_ready), DW'(1));
    chk({tag, "_xbv"}, DW'(xb_valid), DW'(0));
    chk({tag, "_biuv"}, DW'(biu_valid), DW'(0));
    chk({tag, "_last"}, DW'(biu_last), DW'(0));
    chk({tag, "_wqv"}, DW'(wq_valid), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_me"}, DW'(dut.ram_me), DW'(0));
  endtask

  initial begin
    logic [2:0] op;
    int r;
    for (int i = 0; i < 2**AW; i++) known[i] = 1'b0;
    rst = 1'b1;
    isu_valid = 1'b0; opcode = '0; set_way = '0; offset = '0; chan = '0; rob_num = '0;
    wbuf_id = '0; line_state = '0; lf_data = '0;
    xb_ready = 1'b0; biu_ready = 1'b0; wq_ready = 1'b0; rtn_valid = 1'b0; rtn_data = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // WRITE then READ back the same location
    run_op(3'd0, 4'd5, 2'd1, '0, rand_line(), {8{8'hA5}}, 2, 1'b0);
    run_op(3'd1, 4'd5, 2'd1, '0, rand_line(), '0, 0, 1'b0);
    // READ with a 4-cycle xbar stall
    run_op(3'd1, 4'd5, 2'd1, '0, rand_line(), '0, 4, 1'b0);
    // LINEFILL offset 2, states {0:00,1:01,2:01,3:00}: writes 2,3,0
    run_op(3'd2, 4'd7, 2'd2, 8'b00_01_01_00, rand_line(), '0, 0, 1'b0);
    run_op(3'd2, 4'd7, 2'd2, 8'b00_01_01_00, rand_line(), '0, 3, 1'b0);
    // WRITE_BACK states {0:dirty,1:sync,2:dirty,3:empty}, toggling BIU ready
    run_op(3'd3, 4'd7, 2'd0, 8'b00_10_01_10, rand_line(), '0, 1, 1'b1);
    // illegal opcode
    run_op(3'd5, 4'd2, 2'd3, 8'hFF, rand_line(), '0, 0, 1'b0);

    // reset in the middle of a WRITE_BACK beat stall
    isu_valid = 1'b1; opcode = 3'd3; set_way = 4'd7; offset = 2'd0; line_state = 8'hFF;
    chk("rst_accept", DW'(isu_ready), DW'(1));
    repeat (4) @(negedge clk) isu_valid = 1'b0;
    chk("rst_pre_biuv", DW'(biu_valid), DW'(1));
    #2 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd1, 4'd7, 2'd2, '0, rand_line(), '0, 1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = 3'd0;
        2, 3, 9: op = 3'd1;
        4, 5:    op = 3'd2;
        6, 7:    op = 3'd3;
        default: op = 3'($urandom_range(4, 7));
      endcase
      run_op(op, SWW'($urandom_range(0, 3)), OFFW'($urandom), 8'($urandom), rand_line(),
             {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
